// File: rtl/multdiv_unit_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITER  = 32;

  // Counter must be able to hold ITER itself, hence the extra bit.
  function automatic int cnt_width(input int iter);
    return $clog2(iter) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;
endpackage

// File: rtl/multdiv_unit_if.sv
// Start/operand/result bundle between the execute stage and the mult/div unit.
// Latency: n/a (wiring only).
// Backpressure: none; busy is the only stall indication back to the pipeline.
interface multdiv_unit_if import md_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [4:0]       rd_in;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             result_rdy;
  logic             busy;
  logic [4:0]       rd_out;

  // Execute stage side: issues ops, observes completion.
  modport master (
    output ctrl_mult, ctrl_div, data_a, data_b, rd_in,
    input  result, exception, result_rdy, busy, rd_out
  );

  // Unit side.
  modport slave (
    input  ctrl_mult, ctrl_div, data_a, data_b, rd_in,
    output result, exception, result_rdy, busy, rd_out
  );
endinterface

// File: rtl/multdiv_unit_cond_negate.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
// Latency: combinational.
// Backpressure: none.
module cond_negate import md_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);
  // Negating the most negative value yields the same bit pattern, which read
  // as unsigned is exactly its magnitude.
  assign o_val = i_neg ? ((~i_val) + WIDTH'(1)) : i_val;
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: result_rdy in the ITER+1'th cycle after the start edge; div-by-zero in the next cycle.
// Backpressure: none; busy asks the hazard unit to stall, starts while busy are ignored.
module multdiv_unit import md_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic           clk,
  input  logic           clr,
  multdiv_unit_if.slave  bus
);
  localparam int CW = cnt_width(ITER);
  localparam logic [2*WIDTH-1:0] MIN_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  md_state_t          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_sign;
  logic [4:0]         r_rd;
  logic [2*WIDTH-1:0] r_acc;     // product accumulator
  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left each step
  logic [WIDTH:0]     r_mag_b;   // multiplier (shifted right) or divisor (held)
  logic [WIDTH-1:0]   r_dvd;     // dividend bits out, quotient bits in
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic               r_rdy;
  logic               r_busy;
  logic [4:0]         r_rd_out;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_div_q;
  logic [WIDTH-1:0]   w_res_mag;
  logic [WIDTH-1:0]   w_res;
  logic               w_last;
  logic               w_mul_ovf;
  logic               w_div_ovf;

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .i_val(bus.data_a), .i_neg(bus.data_a[WIDTH-1]), .o_val(w_mag_a));
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .i_val(bus.data_b), .i_neg(bus.data_b[WIDTH-1]), .o_val(w_mag_b));
  cond_negate #(.WIDTH(WIDTH)) u_neg_res (
    .i_val(w_res_mag), .i_neg(r_sign), .o_val(w_res));

  // One shift-add step and one restoring-division step on the magnitudes.
  assign w_mul_next = r_acc + (r_mag_b[0] ? r_mcand : '0);
  assign w_trial    = {r_rem, r_dvd[WIDTH-1]};
  assign w_qbit     = (w_trial >= r_mag_b);
  assign w_div_q    = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_last     = (r_cnt == CW'(ITER - 1));

  // Signed range check: a negative result may reach magnitude 2^(WIDTH-1).
  assign w_mul_ovf  = (|w_mul_next[2*WIDTH-1:WIDTH-1]) && !(r_sign && (w_mul_next == MIN_MAG));
  assign w_div_ovf  = !r_sign && w_div_q[WIDTH-1];
  assign w_res_mag  = (r_state == MULT) ? w_mul_next[WIDTH-1:0] : w_div_q;

  assign bus.result     = r_result;
  assign bus.exception  = r_exc;
  assign bus.result_rdy = r_rdy;
  assign bus.busy       = r_busy;
  assign bus.rd_out     = r_rd_out;

  // Control FSM plus iteration datapath; all outputs registered.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_rd     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mag_b  <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
      r_rd_out <= '0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // Operands are captured whenever idle; only a start uses them.
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_sign  <= bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1];
          r_rd    <= bus.rd_in;
          r_acc   <= '0;
          r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
          r_mag_b <= {1'b0, w_mag_b};
          r_dvd   <= w_mag_a;
          r_rem   <= '0;
          if (bus.ctrl_mult) begin
            r_state <= MULT;
            r_busy  <= 1'b1;
          end else if (bus.ctrl_div) begin
            if (bus.data_b == '0) begin
              r_state  <= DONE;
              r_rdy    <= 1'b1;
              r_result <= '0;
              r_exc    <= 1'b1;
              r_rd_out <= bus.rd_in;
            end else begin
              r_state <= DIV;
              r_busy  <= 1'b1;
            end
          end
        end
        MULT, DIV: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_state == MULT) begin
            r_acc   <= w_mul_next;
            r_mcand <= r_mcand << 1;
            r_mag_b <= r_mag_b >> 1;
          end else begin
            r_rem <= w_qbit ? WIDTH'(w_trial - r_mag_b) : w_trial[WIDTH-1:0];
            r_dvd <= w_div_q;
          end
          if (w_last) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_rdy    <= 1'b1;
            r_result <= w_res;
            r_exc    <= (r_state == MULT) ? w_mul_ovf : w_div_ovf;
            r_rd_out <= r_rd;
          end
        end
      endcase
    end
  end
endmodule
